interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Sequences hardware interrupt entry and RTI return for the 5-stage pipeline. It sits beside the decode stage and handles the following:
- freezes fetch and flushes decode;
- drains in-flight instructions;
- injects memory micro-ops to push/pop PC and flags, and to read the interrupt vector;
- reloads PC and flags.

Only one interrupt is pending at a time. There is no nesting.

## Interface
- `DRAIN_CYCLES`, 3, cycles spent draining stages after decode; must be ≥1
- `IVT_ADDR`, 32'h0000_0000, address of vector low word; high word is at `IVT_ADDR+1`

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `interrupt_signal` in 1: interrupt request pulse, latched internally
- `pc_next` in 32: resume PC, sampled on acceptance
- `flags` in 4: current CCR, sampled on last DRAIN cycle
- `branch_in_flight` in 1: unresolved control transfer in decode/execute; blocks acceptance
- `rti_decode` in 1: RTI present in decode
- `mem_rdata` in 16: pop/read data, valid exactly 1 cycle after the issuing uop
- `stall_fetch` out 1: hold PC and fetch register
- `flush_decode` out 1: convert decode contents to bubble
- `uop_valid` out 1: injected memory micro-op this cycle
- `uop_kind` out 2: 00 push, 01 pop, 10 read
- `uop_addr` out 32: read address (`uop_kind`=10 only, else 0)
- `uop_wdata` out 16: push data (`uop_kind`=00 only, else 0)
- `pc_load` out 1: load `pc_load_value` into PC
- `pc_load_value` out 32: target PC
- `flags_load` out 1: load `flags_load_value` into CCR
- `flags_load_value` out 4: restored flags
- `int_ack` out 1: one-cycle pulse on vector jump
- `busy` out 1: state ≠ IDLE

## Operation
- All outputs are Moore, decoded from the registered state.
- After reset, or in IDLE, all outputs are 0.
- The pending flag is set by `interrupt_signal` in any state. It is single-depth: further pulses merge into it. It clears on acceptance.
- In IDLE, RTI has priority: `rti_decode`=1 moves to R_DRAIN. Otherwise, pending & !`branch_in_flight` moves to DRAIN and captures `pc_next` into `saved_pc`.
- Interrupt entry path:
  - DRAIN: lasts `DRAIN_CYCLES` cycles. `flush_decode`=1 in the first cycle only. `flags` is captured on the last cycle.
  - PUSH_PC_H: push `saved_pc[31:16]`.
  - PUSH_PC_L: push `saved_pc[15:0]`.
  - PUSH_FLG: push `{12'b0, saved_flags}`.
  - RD_VEC_L: read `IVT_ADDR`.
  - RD_VEC_H: read `IVT_ADDR+1`; capture `mem_rdata` as vector low.
  - VEC_WAIT: capture `mem_rdata` as vector high.
  - JUMP: `pc_load`=1, `pc_load_value`=vector, `int_ack`=1.
  - Then IDLE.
- RTI return path:
  - R_DRAIN: same timing and flush as DRAIN.
  - POP_FLG: pop.
  - POP_PC_L: pop; capture flags = `mem_rdata[3:0]`.
  - POP_PC_H: pop; capture PC low.
  - R_WAIT: capture PC high.
  - R_JUMP: `pc_load`=1 with `{hi,lo}`; `flags_load`=1 with restored flags.
  - Then IDLE.
- `stall_fetch`=1 and `busy`=1 in every non-IDLE state.
- The interrupt is not accepted in JUMP or R_JUMP. At least one IDLE cycle always separates two sequences.
- If `interrupt_signal` and `rti_decode` arrive in the same IDLE cycle, RTI runs first. The interrupt stays pending and is accepted from the following IDLE cycle.
- A synchronous `reset` in any state:
  - forces IDLE on the next edge;
  - clears pending, the drain counter and all captured registers;
  - drives all outputs to 0 from the next cycle.

## Timing
- Interrupt entry, with acceptance edge at end of cycle 0:
  - DRAIN: cycles 1..D.
  - Pushes: D+1, D+2, D+3.
  - Reads: D+4, D+5.
  - VEC_WAIT: D+6.
  - JUMP: D+7.
  - IDLE: D+8.
  - Total: D+7 busy cycles.
- RTI, with entry edge at end of cycle 0:
  - R_DRAIN: 1..D.
  - Pops: D+1..D+3.
  - R_WAIT: D+4.
  - R_JUMP: D+5.
- `mem_rdata` is sampled on the edge ending the cycle after each read/pop issue. No wait states.
- Acceptance latency: first IDLE cycle with pending & !`branch_in_flight`. Each cycle `branch_in_flight`=1 adds exactly one cycle.

## Test plan
- Reset check: assert `reset` for 2 cycles with `interrupt_signal`=1 → all outputs 0, `busy`=0, no sequence starts after release.
- Interrupt entry, D=3, `pc_next`=0x0000_1234, `flags`=4'b0101, `mem_rdata`=0x0040 then 0x0000:
  - pushes 0x0000, 0x1234, 0x0005 in cycles 4–6;
  - reads at 0x0, 0x1 in cycles 7–8;
  - cycle 10: `pc_load`=1, value 0x0000_0040, `int_ack`=1;
  - IDLE at cycle 11.
- RTI with pops returning 0x0005, 0x1234, 0x0000 → in R_JUMP (cycle 8), `pc_load_value`=0x0000_1234, `flags_load_value`=4'b0101, `int_ack`=0.
- `branch_in_flight` high for 2 cycles while pending → DRAIN starts exactly 2 cycles later than in the unblocked case.
- Simultaneous `interrupt_signal` and `rti_decode`, plus a second interrupt pulse during RTI → full RTI, one IDLE cycle, then exactly one interrupt sequence.
- `reset` asserted during PUSH_PC_L → next cycle IDLE with all outputs 0; no further pushes; the earlier pending interrupt is not serviced.

Source files
------------

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Sequences interrupt entry (drain, push PC/flags, vector fetch,
//            jump) and RTI return (drain, pop flags/PC, reload) for the pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] IVT_ADDR     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt_signal,
    input  logic [31:0] pc_next,
    input  logic [3:0]  flags,
    input  logic        branch_in_flight,
    input  logic        rti_decode,
    input  logic [15:0] mem_rdata,
    output logic        stall_fetch,
    output logic        flush_decode,
    output logic        uop_valid,
    output logic [1:0]  uop_kind,
    output logic [31:0] uop_addr,
    output logic [15:0] uop_wdata,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic        flags_load,
    output logic [3:0]  flags_load_value,
    output logic        int_ack,
    output logic        busy
);

    localparam int            CW           = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] c_DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] c_KIND_PUSH = 2'b00;
    localparam logic [1:0] c_KIND_POP  = 2'b01;
    localparam logic [1:0] c_KIND_READ = 2'b10;

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_DRAIN     = 4'd1;
    localparam logic [3:0] c_PUSH_PC_H = 4'd2;
    localparam logic [3:0] c_PUSH_PC_L = 4'd3;
    localparam logic [3:0] c_PUSH_FLG  = 4'd4;
    localparam logic [3:0] c_RD_VEC_L  = 4'd5;
    localparam logic [3:0] c_RD_VEC_H  = 4'd6;
    localparam logic [3:0] c_VEC_WAIT  = 4'd7;
    localparam logic [3:0] c_JUMP      = 4'd8;
    localparam logic [3:0] c_R_DRAIN   = 4'd9;
    localparam logic [3:0] c_POP_FLG   = 4'd10;
    localparam logic [3:0] c_POP_PC_L  = 4'd11;
    localparam logic [3:0] c_POP_PC_H  = 4'd12;
    localparam logic [3:0] c_R_WAIT    = 4'd13;
    localparam logic [3:0] c_R_JUMP    = 4'd14;

    logic [3:0]    r_state;
    logic          r_pending;
    logic [CW-1:0] r_drain_cnt;
    logic [31:0]   r_saved_pc;
    logic [3:0]    r_saved_flags;
    logic [15:0]   r_vec_lo;
    logic [15:0]   r_vec_hi;
    logic [3:0]    r_rest_flags;
    logic [15:0]   r_rest_pc_lo;
    logic [15:0]   r_rest_pc_hi;
    logic          w_accept;
    logic          w_drain_last;

    // RTI in decode wins over a pending interrupt in the same IDLE cycle.
    always_comb begin
        w_accept     = (r_state == c_IDLE) && !rti_decode && r_pending && !branch_in_flight;
        w_drain_last = (r_drain_cnt == c_DRAIN_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_pending     <= 1'b0;
            r_drain_cnt   <= '0;
            r_saved_pc    <= '0;
            r_saved_flags <= '0;
            r_vec_lo      <= '0;
            r_vec_hi      <= '0;
            r_rest_flags  <= '0;
            r_rest_pc_lo  <= '0;
            r_rest_pc_hi  <= '0;
        end else begin
            // A pulse arriving in the acceptance cycle is a fresh request and survives.
            r_pending <= interrupt_signal | (r_pending & ~w_accept);
            case (r_state)
                c_IDLE: begin
                    r_drain_cnt <= '0;
                    if (rti_decode) begin
                        r_state <= c_R_DRAIN;
                    end else if (w_accept) begin
                        r_state    <= c_DRAIN;
                        r_saved_pc <= pc_next;
                    end
                end
                c_DRAIN: begin
                    if (w_drain_last) begin
                        r_saved_flags <= flags;
                        r_drain_cnt   <= '0;
                        r_state       <= c_PUSH_PC_H;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                c_PUSH_PC_H: r_state <= c_PUSH_PC_L;
                c_PUSH_PC_L: r_state <= c_PUSH_FLG;
                c_PUSH_FLG:  r_state <= c_RD_VEC_L;
                c_RD_VEC_L:  r_state <= c_RD_VEC_H;
                c_RD_VEC_H: begin
                    r_vec_lo <= mem_rdata;
                    r_state  <= c_VEC_WAIT;
                end
                c_VEC_WAIT: begin
                    r_vec_hi <= mem_rdata;
                    r_state  <= c_JUMP;
                end
                c_JUMP: r_state <= c_IDLE;
                c_R_DRAIN: begin
                    if (w_drain_last) begin
                        r_drain_cnt <= '0;
                        r_state     <= c_POP_FLG;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                c_POP_FLG: r_state <= c_POP_PC_L;
                c_POP_PC_L: begin
                    r_rest_flags <= mem_rdata[3:0];
                    r_state      <= c_POP_PC_H;
                end
                c_POP_PC_H: begin
                    r_rest_pc_lo <= mem_rdata;
                    r_state      <= c_R_WAIT;
                end
                c_R_WAIT: begin
                    r_rest_pc_hi <= mem_rdata;
                    r_state      <= c_R_JUMP;
                end
                c_R_JUMP: r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_fetch      = (r_state != c_IDLE);
        busy             = (r_state != c_IDLE);
        flush_decode     = ((r_state == c_DRAIN) || (r_state == c_R_DRAIN)) && (r_drain_cnt == '0);
        uop_valid        = 1'b0;
        uop_kind         = 2'b00;
        uop_addr         = 32'h0;
        uop_wdata        = 16'h0;
        pc_load          = 1'b0;
        pc_load_value    = 32'h0;
        flags_load       = 1'b0;
        flags_load_value = 4'h0;
        int_ack          = 1'b0;
        case (r_state)
            c_PUSH_PC_H: begin
                uop_valid = 1'b1;
                uop_kind  = c_KIND_PUSH;
                uop_wdata = r_saved_pc[31:16];
            end
            c_PUSH_PC_L: begin
                uop_valid = 1'b1;
                uop_kind  = c_KIND_PUSH;
                uop_wdata = r_saved_pc[15:0];
            end
            c_PUSH_FLG: begin
                uop_valid = 1'b1;
                uop_kind  = c_KIND_PUSH;
                uop_wdata = {12'b0, r_saved_flags};
            end
            c_RD_VEC_L: begin
                uop_valid = 1'b1;
                uop_kind  = c_KIND_READ;
                uop_addr  = IVT_ADDR;
            end
            c_RD_VEC_H: begin
                uop_valid = 1'b1;
                uop_kind  = c_KIND_READ;
                uop_addr  = IVT_ADDR + 32'd1;
            end
            c_JUMP: begin
                pc_load       = 1'b1;
                pc_load_value = {r_vec_hi, r_vec_lo};
                int_ack       = 1'b1;
            end
            c_POP_FLG, c_POP_PC_L, c_POP_PC_H: begin
                uop_valid = 1'b1;
                uop_kind  = c_KIND_POP;
            end
            c_R_JUMP: begin
                pc_load          = 1'b1;
                pc_load_value    = {r_rest_pc_hi, r_rest_pc_lo};
                flags_load       = 1'b1;
                flags_load_value = r_rest_flags;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Timeline-based reference model with scoreboard for the interrupt
//            entry / RTI sequencer, plus a stack and vector-table memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    localparam int          D   = 3;
    localparam logic [31:0] IVT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        interrupt_signal = 1'b1;
    logic [31:0] pc_next = 32'h0;
    logic [3:0]  flags = 4'h0;
    logic        branch_in_flight = 1'b0;
    logic        rti_decode = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        stall_fetch, flush_decode, uop_valid, pc_load, flags_load, int_ack, busy;
    logic [1:0]  uop_kind;
    logic [31:0] uop_addr, pc_load_value;
    logic [15:0] uop_wdata;
    logic [3:0]  flags_load_value;

    interrupt_controller #(.DRAIN_CYCLES(D), .IVT_ADDR(IVT)) dut (
        .clk(clk), .reset(reset), .interrupt_signal(interrupt_signal),
        .pc_next(pc_next), .flags(flags), .branch_in_flight(branch_in_flight),
        .rti_decode(rti_decode), .mem_rdata(mem_rdata),
        .stall_fetch(stall_fetch), .flush_decode(flush_decode),
        .uop_valid(uop_valid), .uop_kind(uop_kind), .uop_addr(uop_addr),
        .uop_wdata(uop_wdata), .pc_load(pc_load), .pc_load_value(pc_load_value),
        .flags_load(flags_load), .flags_load_value(flags_load_value),
        .int_ack(int_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [89:0] v;
    } exp_t;

    exp_t        sb[$];
    logic [35:0] m_stack[$];     // {pc, flags} frames pushed by the model
    logic [15:0] mem_stack[$];   // environment stack memory
    logic [15:0] ivt_lo = 16'h0040;
    logic [15:0] ivt_hi = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_lo = 1, m_hi = -1, m_flush = -1, m_flag_cyc = -1, m_acc = 0;
    logic        m_pending = 1'b0;
    logic [31:0] m_pc;
    logic [35:0] m_frame;

    function automatic logic [89:0] pack(input logic uv, input logic [1:0] k, input logic [31:0] a,
                                         input logic [15:0] w, input logic pl, input logic [31:0] plv,
                                         input logic fl, input logic [3:0] flv, input logic ack);
        return {uv, k, a, w, pl, plv, fl, flv, ack};
    endfunction

    function automatic exp_t mk(input int c, input logic [89:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        return e;
    endfunction

    // Reference model: on each decision edge, lay out the expected timeline of the sequence.
    always @(posedge clk) begin
        if (reset) begin
            m_pending = 1'b0;
            if (m_hi > cyc) m_hi = cyc;
            if (m_flush > cyc) m_flush = -1;
            m_flag_cyc = -1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].cyc > cyc) sb.delete(i);
            m_stack.delete();
        end else begin
            if (cyc > m_hi && rti_decode) begin
                m_frame = (m_stack.size() > 0) ? m_stack.pop_back() : 36'h0;
                m_lo = cyc + 1;  m_hi = cyc + D + 5;  m_flush = cyc + 1;
                for (int k = 1; k <= 3; k++)
                    sb.push_back(mk(cyc + D + k, pack(1'b1, 2'b01, 32'h0, 16'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0)));
                sb.push_back(mk(cyc + D + 5, pack(1'b0, 2'b00, 32'h0, 16'h0, 1'b1, m_frame[35:4], 1'b1, m_frame[3:0], 1'b0)));
                m_pending = m_pending | interrupt_signal;
            end else if (cyc > m_hi && m_pending && !branch_in_flight) begin
                m_pc = pc_next;  m_acc = cyc;  m_flag_cyc = cyc + D;
                m_lo = cyc + 1;  m_hi = cyc + D + 7;  m_flush = cyc + 1;
                m_pending = interrupt_signal;
            end else begin
                m_pending = m_pending | interrupt_signal;
            end
            if (cyc == m_flag_cyc) begin
                m_stack.push_back({m_pc, flags});
                sb.push_back(mk(m_acc + D + 1, pack(1'b1, 2'b00, 32'h0, m_pc[31:16], 1'b0, 32'h0, 1'b0, 4'h0, 1'b0)));
                sb.push_back(mk(m_acc + D + 2, pack(1'b1, 2'b00, 32'h0, m_pc[15:0], 1'b0, 32'h0, 1'b0, 4'h0, 1'b0)));
                sb.push_back(mk(m_acc + D + 3, pack(1'b1, 2'b00, 32'h0, {12'h0, flags}, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0)));
                sb.push_back(mk(m_acc + D + 4, pack(1'b1, 2'b10, IVT, 16'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0)));
                sb.push_back(mk(m_acc + D + 5, pack(1'b1, 2'b10, IVT + 32'd1, 16'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0)));
                sb.push_back(mk(m_acc + D + 7, pack(1'b0, 2'b00, 32'h0, 16'h0, 1'b1, {ivt_hi, ivt_lo}, 1'b0, 4'h0, 1'b1)));
            end
        end
        cyc = cyc + 1;
    end

    // Memory: answers pops/reads one cycle after issue, garbage otherwise.
    always @(posedge clk) begin
        if (reset) begin
            mem_stack.delete();
            mem_rdata <= 16'($urandom);
        end else if (uop_valid === 1'b1 && uop_kind == 2'b00) begin
            mem_stack.push_back(uop_wdata);
            mem_rdata <= 16'($urandom);
        end else if (uop_valid === 1'b1 && uop_kind == 2'b01) begin
            mem_rdata <= (mem_stack.size() > 0) ? mem_stack.pop_back() : 16'h0;
        end else if (uop_valid === 1'b1 && uop_kind == 2'b10) begin
            mem_rdata <= (uop_addr == IVT) ? ivt_lo : ((uop_addr == IVT + 32'd1) ? ivt_hi : 16'hBAD0);
        end else begin
            mem_rdata <= 16'($urandom);
        end
    end

    logic        exp_busy, exp_flush, any_out;
    logic [89:0] act_v;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            exp_busy  = (cyc >= m_lo) && (cyc <= m_hi);
            exp_flush = (cyc == m_flush);
            checks++;
            if (busy !== exp_busy || stall_fetch !== exp_busy || flush_decode !== exp_flush) begin
                failures++;
                $display("FAIL status cyc=%0d busy/stall/flush=%b%b%b expected=%b%b%b",
                         cyc, busy, stall_fetch, flush_decode, exp_busy, exp_busy, exp_flush);
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing cyc=%0d expected output at cyc %0d value=%h not seen", cyc, sb[0].cyc, sb[0].v);
                void'(sb.pop_front());
            end
            act_v   = pack(uop_valid, uop_kind, uop_addr, uop_wdata, pc_load, pc_load_value,
                           flags_load, flags_load_value, int_ack);
            any_out = (uop_valid === 1'b1) || (pc_load === 1'b1) || (flags_load === 1'b1) || (int_ack === 1'b1);
            checks++;
            if (any_out) begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    if (act_v !== sb[0].v) begin
                        failures++;
                        $display("FAIL output cyc=%0d got=%h expected=%h", cyc, act_v, sb[0].v);
                    end
                    void'(sb.pop_front());
                end else begin
                    failures++;
                    $display("FAIL unexpected cyc=%0d got=%h expected no output", cyc, act_v);
                end
            end else if (act_v !== 90'h0) begin
                failures++;
                $display("FAIL quiet cyc=%0d got=%h expected all zero", cyc, act_v);
            end
        end
    end

    task automatic drive(input logic r, input logic i, input logic rt, input logic b);
        @(negedge clk);
        reset            = r;
        interrupt_signal = i;
        rti_decode       = rt;
        branch_in_flight = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held two cycles with a request asserted; nothing may start afterwards.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        // Interrupt entry.
        pc_next = 32'h0000_1234;
        flags   = 4'b0101;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(15);
        // RTI returning the frame just pushed.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(12);
        // Branch in flight blocks acceptance for two cycles.
        pc_next = 32'hCAFE_0010;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(15);
        // Simultaneous request and RTI, plus another pulse during the RTI.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(25);
        // Reset landing in PUSH_PC_L with a further request pending.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        // Randomized traffic.
        ivt_lo = 16'($urandom);
        ivt_hi = 16'($urandom);
        for (int n = 0; n < 4000; n++) begin
            pc_next = $urandom;
            flags   = 4'($urandom);
            drive(($urandom_range(0, 399) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(40);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d pending expected outputs, required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
